telemetry_pkt: RTL and testbench



---
 rtl/telemetry_pkt.sv | 145 ++++++++++++++
 tb/tb_telemetry_pkt.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/telemetry_pkt.sv
// telemetry_pkt: periodic telemetry packetizer.
// Snapshots NUM_CH channels of DATA_W bits and sends them as a byte packet
// (HDR0, HDR1, channels MSB-byte first, optional inverted-sum checksum)
// through a trmt/tx_done byte UART handshake.
module telemetry_pkt #(
  parameter int         NUM_CH   = 3,
  parameter int         DATA_W   = 12,
  parameter int         PERIOD   = 1048576,
  parameter logic [7:0] HDR0     = 8'hAA,
  parameter logic [7:0] HDR1     = 8'h55,
  parameter int         CKSUM_EN = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic                     tx_done,
  output logic [7:0]               tx_data,
  output logic                     trmt,
  output logic                     busy,
  output logic                     pkt_done
);

  // Bytes per channel, payload bytes, and total packet length.
  localparam int B  = (DATA_W + 7) / 8;
  localparam int NP = NUM_CH * B;
  localparam int L  = 2 + NP + ((CKSUM_EN != 0) ? 1 : 0);
  localparam int IW = $clog2(L);
  localparam int TW = $clog2(PERIOD);

  localparam logic [IW-1:0] LAST  = IW'(L - 1);
  localparam logic [TW-1:0] T_MAX = TW'(PERIOD - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_LOAD = 2'd2;

  logic [1:0]      state;
  logic [IW-1:0]   byte_idx;
  logic [7:0]      cksum;
  logic [TW-1:0]   timer;
  logic [NP*8-1:0] shadow;
  logic [NP*8-1:0] pad_bytes;
  logic [7:0]      pay_byte;
  logic [7:0]      next_byte;
  logic            is_payload;
  logic            start;

  assign start      = (state == S_IDLE) && en && (timer == T_MAX);
  assign is_payload = (byte_idx >= IW'(2)) && (byte_idx <= IW'(NP + 1));

  // Re-pack ch_data so payload byte j (in transmit order) sits at bits [j*8 +: 8],
  // each channel zero-padded at the top to a whole number of bytes.
  always_comb begin
    logic [B*8-1:0] chan;
    pad_bytes = '0;
    chan      = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      chan             = '0;
      chan[DATA_W-1:0] = ch_data[k*DATA_W +: DATA_W];
      for (int unsigned b = 0; b < B; b++) begin
        pad_bytes[(k*B + b)*8 +: 8] = chan[(B-1-b)*8 +: 8];
      end
    end
  end

  // Select the shadowed payload byte addressed by byte_idx.
  always_comb begin
    pay_byte = '0;
    for (int unsigned j = 0; j < NP; j++) begin
      if (byte_idx == IW'(j + 2)) pay_byte = shadow[j*8 +: 8];
    end
  end

  // Byte to issue for the current byte_idx: headers, payload, then checksum.
  always_comb begin
    if (byte_idx == '0)            next_byte = HDR0;
    else if (byte_idx == IW'(1))   next_byte = HDR1;
    else if (is_payload)           next_byte = pay_byte;
    else                           next_byte = ~cksum;
  end

  // Period timer: cleared on packet start, counts up and saturates at PERIOD-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                timer <= T_MAX;
    else if (start)            timer <= '0;
    else if (timer != T_MAX)   timer <= timer + TW'(1);
  end

  // Channel snapshot taken on packet start; the packet is built from it only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      shadow <= '0;
    else if (start)  shadow <= pad_bytes;
  end

  // Packet sequencer. S_LOAD gives the one-cycle gap between tx_done and the
  // next trmt; the checksum accumulates as each payload byte is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      byte_idx <= '0;
      cksum    <= '0;
      tx_data  <= '0;
      trmt     <= 1'b0;
      busy     <= 1'b0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            tx_data  <= HDR0;
            trmt     <= 1'b1;
            byte_idx <= '0;
            cksum    <= '0;
            busy     <= 1'b1;
            state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (trmt) begin
            trmt <= 1'b0;
          end else if (tx_done) begin
            if (byte_idx == LAST) begin
              pkt_done <= 1'b1;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end else begin
              byte_idx <= byte_idx + IW'(1);
              state    <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          tx_data <= next_byte;
          trmt    <= 1'b1;
          if (is_payload) cksum <= cksum + next_byte;
          state   <= S_SEND;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_telemetry_pkt.sv
// tb_telemetry_pkt: self-checking bench for telemetry_pkt. Four instances with
// different parameter sets, a UART responder/byte capture per instance, and a
// byte-list reference model computed from channel values with plain arithmetic.
module tb_telemetry_pkt;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en [4];
  logic        inj [4];
  logic        tx_done_v [4];
  logic        trmt_v [4];
  logic [7:0]  txd_v [4];
  logic        busy_v [4];
  logic        pd_v [4];
  logic [35:0] ch_u0, ch_u1;
  logic [31:0] ch_u2;
  logic [39:0] ch_u3;

  int n_err = 0;
  int n_checks = 0;

  initial forever #5 clk = ~clk;

  telemetry_pkt #(.NUM_CH(3), .DATA_W(12), .PERIOD(200), .HDR0(8'hAA), .HDR1(8'h55), .CKSUM_EN(1)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en[0]), .ch_data(ch_u0), .tx_done(tx_done_v[0] | inj[0]),
    .tx_data(txd_v[0]), .trmt(trmt_v[0]), .busy(busy_v[0]), .pkt_done(pd_v[0]));

  telemetry_pkt #(.NUM_CH(3), .DATA_W(12), .PERIOD(20), .HDR0(8'hAA), .HDR1(8'h55), .CKSUM_EN(1)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en[1]), .ch_data(ch_u1), .tx_done(tx_done_v[1] | inj[1]),
    .tx_data(txd_v[1]), .trmt(trmt_v[1]), .busy(busy_v[1]), .pkt_done(pd_v[1]));

  telemetry_pkt #(.NUM_CH(2), .DATA_W(16), .PERIOD(64), .HDR0(8'hAA), .HDR1(8'h55), .CKSUM_EN(0)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en[2]), .ch_data(ch_u2), .tx_done(tx_done_v[2] | inj[2]),
    .tx_data(txd_v[2]), .trmt(trmt_v[2]), .busy(busy_v[2]), .pkt_done(pd_v[2]));

  telemetry_pkt #(.NUM_CH(2), .DATA_W(20), .PERIOD(50), .HDR0(8'hC3), .HDR1(8'h3C), .CKSUM_EN(1)) u3 (
    .clk(clk), .rst_n(rst_n), .en(en[3]), .ch_data(ch_u3), .tx_done(tx_done_v[3] | inj[3]),
    .tx_data(txd_v[3]), .trmt(trmt_v[3]), .busy(busy_v[3]), .pkt_done(pd_v[3]));

  // Capture state, written only by the monitor process.
  int         cyc_n = 0;
  logic [7:0] cap [4][1024];
  int         tcyc [4][1024];
  int         cap_n [4];
  int         pd_cyc [4][64];
  int         pd_n [4];
  int         pend [4];
  logic       prev_t [4];
  int         width_err [4];
  int         busy_err [4];
  int         lat [4];

  initial forever begin
    @(posedge clk);
    cyc_n++;
  end

  // UART responder and byte capture: tx_done arrives lat clocks after each trmt.
  initial begin
    for (int i = 0; i < 4; i++) begin
      tx_done_v[i] = 1'b0; cap_n[i] = 0; pd_n[i] = 0; pend[i] = 0;
      prev_t[i] = 1'b0; width_err[i] = 0; busy_err[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        tx_done_v[i] = 1'b0;
        if (!rst_n) begin
          pend[i]   = 0;
          prev_t[i] = 1'b0;
        end else begin
          if (pend[i] > 0) begin
            pend[i]--;
            if (pend[i] == 0) tx_done_v[i] = 1'b1;
          end
          if (trmt_v[i]) begin
            if (prev_t[i]) width_err[i]++;
            if (!busy_v[i]) busy_err[i]++;
            if (cap_n[i] < 1024) begin
              cap[i][cap_n[i]]  = txd_v[i];
              tcyc[i][cap_n[i]] = cyc_n;
            end
            cap_n[i]++;
            pend[i] = lat[i] - 1;
          end
          prev_t[i] = trmt_v[i];
          if (pd_v[i]) begin
            if (busy_v[i]) busy_err[i]++;
            if (pd_n[i] < 64) pd_cyc[i][pd_n[i]] = cyc_n;
            pd_n[i]++;
          end
        end
      end
    end
  end

  // Reference model: expected packet byte list from channel values.
  logic [31:0] cv [4];
  logic [7:0]  exp_b [64];
  int          exp_n;

  function automatic void build(input int nch, input int w, input int ck,
                                input logic [7:0] h0, input logic [7:0] h1);
    int nb;
    int sum;
    longint unsigned v;
    nb = (w + 7) / 8;
    sum = 0;
    exp_n = 0;
    exp_b[exp_n] = h0; exp_n++;
    exp_b[exp_n] = h1; exp_n++;
    for (int k = 0; k < nch; k++) begin
      v = longint'(cv[k]) & ((64'd1 << w) - 64'd1);
      for (int b = nb - 1; b >= 0; b--) begin
        exp_b[exp_n] = 8'((v >> (8 * b)) & 64'hFF);
        sum = sum + int'((v >> (8 * b)) & 64'hFF);
        exp_n++;
      end
    end
    if (ck != 0) begin
      exp_b[exp_n] = ~(8'(sum));
      exp_n++;
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_pkt(input int i, input int base, input string tag);
    for (int k = 0; k < exp_n; k++)
      chk($sformatf("%s_b%0d", tag, k), 64'(cap[i][base + k]), 64'(exp_b[k]));
  endtask

  task automatic wait_pd(input int i, input int target, input int budget, input string tag);
    int k = 0;
    while (pd_n[i] < target && k < budget) begin
      @(negedge clk); #1; k++;
    end
    chk(tag, 64'(pd_n[i] >= target), 64'd1);
  endtask

  task automatic wait_cap(input int i, input int target, input int budget, input string tag);
    int k = 0;
    while (cap_n[i] < target && k < budget) begin
      @(negedge clk); #1; k++;
    end
    chk(tag, 64'(cap_n[i] >= target), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, p, c, rb, pr;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin en[i] = 1'b0; inj[i] = 1'b0; lat[i] = 10; end
    ch_u0 = '0; ch_u1 = '0; ch_u2 = '0; ch_u3 = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_trmt%0d", i), 64'(trmt_v[i]), 64'd0);
      chk($sformatf("rst_busy%0d", i), 64'(busy_v[i]), 64'd0);
      chk($sformatf("rst_txd%0d", i), 64'(txd_v[i]), 64'd0);
      chk($sformatf("rst_pd%0d", i), 64'(pd_v[i]), 64'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Byte order, checksum, period on u0.
    cv[0] = 32'hABC; cv[1] = 32'h123; cv[2] = 32'hFFF;
    ch_u0 = {12'hFFF, 12'h123, 12'hABC};
    b = cap_n[0]; p = pd_n[0];
    en[0] = 1'b1; c = cyc_n;
    wait_pd(0, p + 2, 1000, "u0_two_pkts");
    build(3, 12, 1, 8'hAA, 8'h55);
    check_pkt(0, b, "u0_p0");
    check_pkt(0, b + 9, "u0_p1");
    chk("u0_first_start", 64'(tcyc[0][b]), 64'(c + 1));
    chk("u0_cksum_lit", 64'(cap[0][b + 8]), 64'h07);
    chk("u0_period", 64'(tcyc[0][b + 9] - tcyc[0][b]), 64'd200);
    chk("u0_pd_after_last", 64'(pd_cyc[0][p] - tcyc[0][b + 8]), 64'd10);

    // Snapshot: change ch0 after byte 2 of the third packet.
    wait_cap(0, b + 21, 400, "u0_p2_byte2");
    ch_u0[11:0] = 12'h456;
    wait_pd(0, p + 4, 1000, "u0_snap_pkts");
    check_pkt(0, b + 18, "u0_snap_old");
    cv[0] = 32'h456;
    build(3, 12, 1, 8'hAA, 8'h55);
    check_pkt(0, b + 27, "u0_snap_new");

    // Enable dropped mid-packet.
    wait_cap(0, b + 41, 600, "u0_p4_byte4");
    en[0] = 1'b0;
    wait_pd(0, p + 5, 600, "u0_en_drop_done");
    check_pkt(0, b + 36, "u0_en_drop");
    repeat (300) @(negedge clk);
    chk("u0_idle_no_trmt", 64'(cap_n[0]), 64'(b + 45));
    chk("u0_idle_no_pd", 64'(pd_n[0]), 64'(p + 5));
    en[0] = 1'b1; c = cyc_n;
    wait_cap(0, b + 46, 5, "u0_restart_seen");
    chk("u0_restart_edge", 64'(tcyc[0][b + 45]), 64'(c + 1));

    // Reset mid-packet, during byte 4.
    wait_cap(0, b + 50, 200, "u0_rst_byte4");
    #1 rst_n = 1'b0;
    #1;
    chk("u0_rst_async_trmt", 64'(trmt_v[0]), 64'd0);
    chk("u0_rst_async_busy", 64'(busy_v[0]), 64'd0);
    chk("u0_rst_async_txd", 64'(txd_v[0]), 64'd0);
    repeat (3) @(negedge clk);
    rb = cap_n[0]; pr = pd_n[0];
    chk("u0_rst_no_bytes", 64'(rb), 64'(b + 50));
    rst_n = 1'b1;
    wait_pd(0, pr + 1, 300, "u0_after_rst_done");
    en[0] = 1'b0;
    check_pkt(0, rb, "u0_after_rst");
    chk("u0_after_rst_len", 64'(cap_n[0] - rb), 64'd9);

    // Overrun on u1: packet longer than PERIOD.
    for (int k = 0; k < 3; k++) cv[k] = $urandom & 32'hFFF;
    ch_u1 = {cv[2][11:0], cv[1][11:0], cv[0][11:0]};
    b = cap_n[1]; p = pd_n[1];
    en[1] = 1'b1;
    wait_pd(1, p + 3, 2000, "u1_three_pkts");
    en[1] = 1'b0;
    build(3, 12, 1, 8'hAA, 8'h55);
    check_pkt(1, b, "u1_p0");
    check_pkt(1, b + 9, "u1_p1");
    check_pkt(1, b + 18, "u1_p2");
    chk("u1_overrun_gap1", 64'(tcyc[1][b + 9] - pd_cyc[1][p]), 64'd1);
    chk("u1_overrun_gap2", 64'(tcyc[1][b + 18] - pd_cyc[1][p + 1]), 64'd1);
    repeat (30) @(negedge clk);
    chk("u1_overrun_len", 64'(cap_n[1] - b), 64'd27);

    // Randomized channels and UART latency on u1 and u3.
    for (int it = 0; it < 5; it++) begin
      lat[1] = int'($urandom_range(15, 2));
      for (int k = 0; k < 3; k++) cv[k] = $urandom;
      ch_u1 = {cv[2][11:0], cv[1][11:0], cv[0][11:0]};
      build(3, 12, 1, 8'hAA, 8'h55);
      b = cap_n[1]; p = pd_n[1];
      en[1] = 1'b1;
      wait_pd(1, p + 1, 1000, $sformatf("u1_rnd%0d_done", it));
      en[1] = 1'b0;
      repeat (2) @(negedge clk);
      check_pkt(1, b, $sformatf("u1_rnd%0d", it));
      chk($sformatf("u1_rnd%0d_len", it), 64'(cap_n[1] - b), 64'(exp_n));

      lat[3] = int'($urandom_range(15, 2));
      for (int k = 0; k < 2; k++) cv[k] = $urandom;
      ch_u3 = {cv[1][19:0], cv[0][19:0]};
      build(2, 20, 1, 8'hC3, 8'h3C);
      b = cap_n[3]; p = pd_n[3];
      en[3] = 1'b1;
      wait_pd(3, p + 1, 1000, $sformatf("u3_rnd%0d_done", it));
      en[3] = 1'b0;
      repeat (2) @(negedge clk);
      check_pkt(3, b, $sformatf("u3_rnd%0d", it));
      chk($sformatf("u3_rnd%0d_len", it), 64'(cap_n[3] - b), 64'(exp_n));
    end

    // Generics on u2: two 16-bit channels, no checksum.
    cv[0] = 32'h1234; cv[1] = 32'h00FF;
    ch_u2 = {16'h00FF, 16'h1234};
    b = cap_n[2]; p = pd_n[2];
    en[2] = 1'b1;
    wait_pd(2, p + 1, 500, "u2_done");
    en[2] = 1'b0;
    build(2, 16, 0, 8'hAA, 8'h55);
    repeat (5) @(negedge clk);
    check_pkt(2, b, "u2_pkt");
    chk("u2_len", 64'(cap_n[2] - b), 64'd6);
    chk("u2_last_byte", 64'(cap[2][b + 5]), 64'hFF);

    // tx_done while idle is ignored.
    inj[2] = 1'b1;
    @(negedge clk);
    inj[2] = 1'b0;
    repeat (10) @(negedge clk);
    chk("u2_idle_txdone_trmt", 64'(cap_n[2] - b), 64'd6);
    chk("u2_idle_txdone_pd", 64'(pd_n[2]), 64'(p + 1));
    chk("u2_idle_txdone_busy", 64'(busy_v[2]), 64'd0);

    for (int i = 0; i < 4; i++) begin
      chk($sformatf("trmt_width%0d", i), 64'(width_err[i]), 64'd0);
      chk($sformatf("busy_flag%0d", i), 64'(busy_err[i]), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
